// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: PC step, default reset vector, fetch-queue entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int PC_STEP      = 4;
   localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

   typedef logic [XLEN_DEFAULT-1:0] instr_t;

   typedef struct packed {
      instr_t instr;
      instr_t incremented_pc;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with clear; count tracks occupancy 0..DEPTH.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign pop_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single-cycle imem requests, buffers words in a prefetch queue.
// Latency: request in cycle t, pushed end of t+1, out_valid in t+2; redirect in t gives out_valid in t+3.
// Backpressure: stops issuing when queued + in-flight entries would exceed DEPTH; redirect kills in-flight data.
module fetch_unit
   import mips_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instruction,
   output logic [XLEN-1:0] out_incremented_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] incremented_pc;
   } entry_t;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] req_addr;
   logic            inflight;
   logic [CW-1:0]   count;
   logic [CW-1:0]   occupancy;
   logic            pop;
   logic            push;
   logic            issue;
   entry_t          push_ent;
   entry_t          head_ent;

   assign out_valid = (count != '0) & !redirect_valid & !rst;
   assign pop       = out_valid & out_ready;

   // An in-flight request already owns a queue slot; a same-cycle pop frees one.
   assign occupancy = count + CW'(inflight) - CW'(pop);
   assign issue     = !rst & !redirect_valid & (occupancy < CW'(DEPTH));

   assign imem_req  = issue;
   assign imem_addr = pc;

   // A killed request has inflight cleared, so only live responses are pushed.
   assign push                    = inflight & !redirect_valid & !rst;
   assign push_ent.instr          = imem_rdata;
   assign push_ent.incremented_pc = req_addr + XLEN'(PC_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         inflight <= 1'b0;
         req_addr <= RESET_PC;
      end else if (redirect_valid) begin
         pc       <= {redirect_pc[XLEN-1:2], 2'b00};
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc       <= pc + XLEN'(PC_STEP);
            req_addr <= pc;
         end
      end
   end

   sync_fifo #(
      .WIDTH (2 * XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .clr      (rst | redirect_valid),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .pop_dat  (head_ent),
      .count    (count)
   );

   assign out_instruction    = head_ent.instr;
   assign out_incremented_pc = head_ent.incremented_pc;

endmodule
